// File: rtl/mem_cmd_pkg.sv
// Shared constants for the memory command sequencer: state encodings,
// default command encodings, grant bit positions and counter sizing.
package mem_cmd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACT  = 2'd1;
  localparam logic [1:0] ST_OP   = 2'd2;
  localparam logic [1:0] ST_REC  = 2'd3;

  localparam logic [2:0] DEF_CMD_NOP = 3'b111;
  localparam logic [2:0] DEF_CMD_ACT = 3'b011;
  localparam logic [2:0] DEF_CMD_WR  = 3'b101;
  localparam logic [2:0] DEF_CMD_RD  = 3'b110;

  localparam int unsigned GNT_WR = 1;
  localparam int unsigned GNT_RD = 0;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter must hold values up to the largest of the beat/recovery counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/mem_cmd_arb.sv
// Two-requester arbiter: fixed write priority or round-robin on ties.
// Grant is combinational; only the last-grant direction is stored.
module mem_cmd_arb
  import mem_cmd_pkg::*;
#(
  parameter int unsigned ARB_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_wr;

  always_comb begin
    grant = '0;
    if (en) begin
      if (wr_req && rd_req) begin
        // Round-robin tie goes opposite the previous winner; reset value favours write.
        if (ARB_MODE == 0 || !last_wr) grant[GNT_WR] = 1'b1;
        else                           grant[GNT_RD] = 1'b1;
      end else if (wr_req) begin
        grant[GNT_WR] = 1'b1;
      end else if (rd_req) begin
        grant[GNT_RD] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         last_wr <= 1'b0;
    else if (|grant) last_wr <= grant[GNT_WR];
  end

endmodule

// File: rtl/mem_cmd_seq.sv
// Memory command sequencer: ACT, LEN beats of WR/RD with incrementing
// address, then TREC recovery NOPs; back-to-back grants on the final cycle.
module mem_cmd_seq
  import mem_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CMD_W    = 3,
  parameter int unsigned WR_LEN   = 2,
  parameter int unsigned RD_LEN   = 2,
  parameter int unsigned TREC     = 1,
  parameter int unsigned ARB_MODE = 0,
  parameter logic [CMD_W-1:0] CMD_NOP = CMD_W'(DEF_CMD_NOP),
  parameter logic [CMD_W-1:0] CMD_ACT = CMD_W'(DEF_CMD_ACT),
  parameter logic [CMD_W-1:0] CMD_WR  = CMD_W'(DEF_CMD_WR),
  parameter logic [CMD_W-1:0] CMD_RD  = CMD_W'(DEF_CMD_RD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic [CMD_W-1:0]  cmd,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              is_write,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = cnt_width(WR_LEN, RD_LEN, TREC);
  localparam int unsigned REC_LAST_I = (TREC == 0) ? 0 : TREC - 1;
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_LEN - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_LEN - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(REC_LAST_I);

  logic [1:0]        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [CMD_W-1:0]  cmd_n;
  logic [ADDR_W-1:0] addr_n;
  logic              wr_n, wack_n, rack_n, done_n;
  logic              op_last, rec_last, final_cyc, grant_en;
  logic [1:0]        grant;

  assign op_last   = (state == ST_OP) && (cnt == (is_write ? WR_LAST : RD_LAST));
  assign rec_last  = (state == ST_REC) && (cnt == REC_LAST);
  assign final_cyc = (TREC == 0) ? op_last : rec_last;
  assign grant_en  = (state == ST_IDLE) || final_cyc;

  mem_cmd_arb #(
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .wr_req(wr_req),
    .rd_req(rd_req),
    .en    (grant_en),
    .grant (grant)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cmd_n   = cmd;
    addr_n  = cmd_addr;
    wr_n    = is_write;
    wack_n  = 1'b0;
    rack_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_ACT: begin
        state_n = ST_OP;
        cnt_n   = '0;
        cmd_n   = is_write ? CMD_WR : CMD_RD;
      end
      ST_OP: begin
        if (op_last) begin
          cnt_n = '0;
          cmd_n = CMD_NOP;
          if (TREC == 0) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_REC;
          end
        end else begin
          cnt_n  = cnt + CW'(1);
          addr_n = cmd_addr + ADDR_W'(1);
        end
      end
      ST_REC: begin
        if (rec_last) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          cmd_n   = CMD_NOP;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A grant overrides the IDLE move but keeps done, giving back-to-back ACT.
    if (|grant) begin
      state_n = ST_ACT;
      cnt_n   = '0;
      cmd_n   = CMD_ACT;
      addr_n  = addr_in;
      wr_n    = grant[GNT_WR];
      wack_n  = grant[GNT_WR];
      rack_n  = grant[GNT_RD];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cmd      <= CMD_NOP;
      cmd_addr <= '0;
      is_write <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cmd      <= cmd_n;
      cmd_addr <= addr_n;
      is_write <= wr_n;
      wr_ack   <= wack_n;
      rd_ack   <= rack_n;
      busy     <= (state_n != ST_IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_mem_cmd_seq.sv
// Directed bench for mem_cmd_seq: per-cycle vector table on the default
// configuration, plus arbitration and back-to-back sequences.
module tb_mem_cmd_seq;

  localparam logic [2:0] N = 3'b111;
  localparam logic [2:0] A = 3'b011;
  localparam logic [2:0] W = 3'b101;
  localparam logic [2:0] R = 3'b110;

  typedef struct packed {
    logic [2:0] in;     // rst, wr_req, rd_req
    logic [7:0] addr;
    logic [2:0] cmd;
    logic [7:0] caddr;
    logic [4:0] flags;  // wr_ack, rd_ack, busy, done, is_write
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       d_wr = 1'b0, d_rd = 1'b0;
  logic [7:0] d_addr = '0;
  logic       d_wack, d_rack, d_iw, d_busy, d_done;
  logic [2:0] d_cmd;
  logic [7:0] d_caddr;

  logic       r_wr = 1'b0, r_rd = 1'b0;
  logic [7:0] r_addr = '0;
  logic       r_wack, r_rack, r_iw, r_busy, r_done;
  logic [2:0] r_cmd;
  logic [7:0] r_caddr;

  logic       b_wr = 1'b0, b_rd = 1'b0;
  logic [7:0] b_addr = '0;
  logic       b_wack, b_rack, b_iw, b_busy, b_done;
  logic [2:0] b_cmd;
  logic [7:0] b_caddr;

  int vectors = 0;
  int miscompares = 0;

  mem_cmd_seq u_dut (
    .clk(clk), .rst(rst), .wr_req(d_wr), .rd_req(d_rd), .addr_in(d_addr),
    .wr_ack(d_wack), .rd_ack(d_rack), .cmd(d_cmd), .cmd_addr(d_caddr),
    .is_write(d_iw), .busy(d_busy), .done(d_done)
  );

  mem_cmd_seq #(.ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .wr_req(r_wr), .rd_req(r_rd), .addr_in(r_addr),
    .wr_ack(r_wack), .rd_ack(r_rack), .cmd(r_cmd), .cmd_addr(r_caddr),
    .is_write(r_iw), .busy(r_busy), .done(r_done)
  );

  mem_cmd_seq #(.WR_LEN(1), .TREC(0)) u_b2b (
    .clk(clk), .rst(rst), .wr_req(b_wr), .rd_req(b_rd), .addr_in(b_addr),
    .wr_ack(b_wack), .rd_ack(b_rack), .cmd(b_cmd), .cmd_addr(b_caddr),
    .is_write(b_iw), .busy(b_busy), .done(b_done)
  );

  function automatic vec_t v(input logic [2:0] in, input logic [7:0] addr,
                             input logic [2:0] c, input logic [7:0] ca,
                             input logic [4:0] fl);
    vec_t t;
    t.in = in; t.addr = addr; t.cmd = c; t.caddr = ca; t.flags = fl;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // Default config: write, read with wrap, write-then-read back-to-back,
    // reset mid-write, then a write with requests ignored while busy.
    vecs.push_back(v(3'b100, 8'h00, N, 8'h00, 5'b00000));
    vecs.push_back(v(3'b010, 8'h10, A, 8'h10, 5'b10101));
    vecs.push_back(v(3'b000, 8'h00, W, 8'h10, 5'b00101));
    vecs.push_back(v(3'b000, 8'h00, W, 8'h11, 5'b00101));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h11, 5'b00101));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h11, 5'b00011));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h11, 5'b00001));
    vecs.push_back(v(3'b001, 8'hFF, A, 8'hFF, 5'b01100));
    vecs.push_back(v(3'b000, 8'h00, R, 8'hFF, 5'b00100));
    vecs.push_back(v(3'b000, 8'h00, R, 8'h00, 5'b00100));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h00, 5'b00100));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h00, 5'b00010));
    vecs.push_back(v(3'b011, 8'h40, A, 8'h40, 5'b10101));
    vecs.push_back(v(3'b001, 8'h80, W, 8'h40, 5'b00101));
    vecs.push_back(v(3'b001, 8'h80, W, 8'h41, 5'b00101));
    vecs.push_back(v(3'b001, 8'h80, N, 8'h41, 5'b00101));
    vecs.push_back(v(3'b001, 8'h80, A, 8'h80, 5'b01110));
    vecs.push_back(v(3'b000, 8'h00, R, 8'h80, 5'b00100));
    vecs.push_back(v(3'b000, 8'h00, R, 8'h81, 5'b00100));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h81, 5'b00100));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h81, 5'b00010));
    vecs.push_back(v(3'b010, 8'h20, A, 8'h20, 5'b10101));
    vecs.push_back(v(3'b000, 8'h00, W, 8'h20, 5'b00101));
    vecs.push_back(v(3'b100, 8'h00, N, 8'h00, 5'b00000));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h00, 5'b00000));
    vecs.push_back(v(3'b010, 8'h30, A, 8'h30, 5'b10101));
    vecs.push_back(v(3'b001, 8'h00, W, 8'h30, 5'b00101));
    vecs.push_back(v(3'b001, 8'h00, W, 8'h31, 5'b00101));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h31, 5'b00101));
    vecs.push_back(v(3'b000, 8'h00, N, 8'h31, 5'b00011));

    foreach (vecs[i]) begin
      rst    = vecs[i].in[2];
      d_wr   = vecs[i].in[1];
      d_rd   = vecs[i].in[0];
      d_addr = vecs[i].addr;
      tick();
      check($sformatf("vec%0d {cmd,addr,wack,rack,busy,done,iw}", i),
            32'({d_cmd, d_caddr, d_wack, d_rack, d_busy, d_done, d_iw}),
            32'({vecs[i].cmd, vecs[i].caddr, vecs[i].flags}));
    end
    rst = 1'b0; d_wr = 1'b0; d_rd = 1'b0;

    // Fixed priority, both held: write wins every time.
    d_wr = 1'b1; d_rd = 1'b1; d_addr = 8'h00;
    for (int i = 0; i < 12; i++) begin
      logic [2:0] ec;
      tick();
      case (i % 4)
        0:       ec = A;
        1, 2:    ec = W;
        default: ec = N;
      endcase
      check($sformatf("fixed%0d {cmd,wack,rack,done}", i),
            32'({d_cmd, d_wack, d_rack, d_done}),
            32'({ec, (i % 4 == 0), 1'b0, (i % 4 == 0 && i > 0)}));
    end
    d_wr = 1'b0; d_rd = 1'b0;
    repeat (3) tick();
    check("fixed idle busy", 32'(d_busy), 32'(0));

    // Round-robin, both held: W, R, W, R.
    r_wr = 1'b1; r_rd = 1'b1; r_addr = 8'h07;
    for (int i = 0; i < 16; i++) begin
      logic ew, er;
      tick();
      ew = (i % 4 == 0) && ((i / 4) % 2 == 0);
      er = (i % 4 == 0) && ((i / 4) % 2 == 1);
      check($sformatf("rr%0d {wack,rack,done}", i),
            32'({r_wack, r_rack, r_done}),
            32'({ew, er, (i % 4 == 0 && i > 0)}));
    end
    r_wr = 1'b0; r_rd = 1'b0;
    repeat (4) tick();
    check("rr idle busy", 32'(r_busy), 32'(0));

    // WR_LEN=1, TREC=0: ACT, WR, ACT, WR ... with done on repeated ACTs.
    b_wr = 1'b1; b_addr = 8'h55;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("b2b%0d {cmd,addr,wack,done}", i),
            32'({b_cmd, b_caddr, b_wack, b_done}),
            32'({(i % 2 == 0) ? A : W, 8'h55, (i % 2 == 0), (i % 2 == 0 && i > 0)}));
    end
    b_wr = 1'b0;
    repeat (3) tick();
    check("b2b idle {cmd,busy}", 32'({b_cmd, b_busy}), 32'({N, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_cmd_seq.md
Name: mem_cmd_seq

Overview:
Parametrised memory command sequencer. It arbitrates level-held write/read requests and issues a registered command stream: ACT, then LEN beats of WR or RD with an incrementing address, then TREC recovery NOPs. It is the generalised successor of the two-phase wr/rd command state machine and sits between the request logic and the memory command bus. All states have distinct encodings, so no state aliasing is possible.

Parameters:
ADDR_W, 8, width of request and command address
CMD_W, 3, width of cmd bus
WR_LEN, 2, WR beats per write transaction (1..256)
RD_LEN, 2, RD beats per read transaction (1..256)
TREC, 1, NOP recovery cycles after the last beat (0..255)
ARB_MODE, 0, 0 = fixed write priority; 1 = round-robin
CMD_NOP, 3'b111, idle/recovery encoding
CMD_ACT, 3'b011, activate encoding
CMD_WR, 3'b101, write-beat encoding
CMD_RD, 3'b110, read-beat encoding

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
wr_req  in  1  write request, held high until wr_ack
rd_req  in  1  read request, held high until rd_ack
addr_in  in  ADDR_W  base address, sampled on the grant edge
wr_ack  out  1  one-cycle grant pulse for the write request
rd_ack  out  1  one-cycle grant pulse for the read request
cmd  out  CMD_W  registered command
cmd_addr  out  ADDR_W  registered address qualifying cmd
is_write  out  1  direction of the current/last transaction
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after a transaction's final cycle

Behaviour:
- Reset (sync, rst=1 at an edge) forces the following values, regardless of state:
  - state=IDLE, cmd=CMD_NOP, cmd_addr=0, is_write=0
  - wr_ack=0, rd_ack=0, busy=0, done=0
  - beat counter=0, last_grant=read
- Reset mid-transaction aborts immediately; no done pulse is produced.
- States: IDLE, ACT, OP, REC.
- All outputs are registered and computed from the next state. No combinational paths run from inputs to outputs.
- Grant:
  - Evaluated at an edge where the state is IDLE, or in a transaction's final cycle (back-to-back).
  - The edge moves to ACT and sets cmd=CMD_ACT, cmd_addr=addr_in, is_write=granted direction, and the matching ack=1 for exactly one cycle.
- Arbitration:
  - ARB_MODE=0: wr_req wins over rd_req.
  - ARB_MODE=1: on a tie, the direction opposite last_grant wins. last_grant updates on every grant. The first tie after reset goes to write.
  - A single requester always wins.
  - A request dropped before its ack is never granted.
- ACT lasts 1 cycle, then OP.
- OP:
  - Lasts LEN cycles (WR_LEN or RD_LEN, selected by is_write). cmd=CMD_WR or CMD_RD.
  - cmd_addr = base on beat 0, +1 on each following beat, wrapping modulo 2^ADDR_W.
- REC: TREC cycles of cmd=CMD_NOP, with cmd_addr held. If TREC=0, REC is skipped.
- Final cycle = last REC cycle, or the last OP beat if TREC=0.
- After the final cycle:
  - done=1 for one cycle.
  - If a request is pending, the grant happens on that same edge: cmd=ACT with no idle gap, so done and ack are high together.
  - Otherwise the block goes to IDLE with cmd=CMD_NOP.
- Requests arriving during ACT/OP/REC are ignored until the final cycle. Requests are not queued.
- Beat counter width is $clog2(max(WR_LEN,RD_LEN,TREC)+1). It reloads on each state entry.
- Latency: request high before edge E0 → cmd=ACT in the cycle after E0. First data beat follows one cycle later.

Decomposition:
- Package mem_cmd_pkg holds:
  - state localparams (IDLE/ACT/OP/REC, one-hot or binary, all distinct)
  - default cmd encodings
  - a helper function for max/clog2
- One sub-module, mem_cmd_arb: a two-requester fixed/round-robin arbiter.
  - Inputs: wr_req, rd_req, grant-enable.
  - Outputs: one-hot grant.
  - Holds the last_grant flop.
- The FSM, counter, and address incrementer live in mem_cmd_seq.

Test Plan:
- Defaults, wr_req=1 with addr_in=0x10 before E0 (dropped on ack) → cyc1: ACT/0x10, wr_ack=1; cyc2–3: WR 0x10, 0x11; cyc4: NOP; cyc5: done=1, then IDLE, busy=0.
- rd_req with addr_in=0xFF → cyc1: ACT/0xFF, rd_ack; cyc2: RD 0xFF; cyc3: RD 0x00 (wrap); cyc4: NOP; cyc5: done.
- ARB_MODE=0, wr_req and rd_req both high at E0 → write granted first. In cyc5, done=1, rd_ack=1 and cmd=ACT simultaneously, with no NOP gap.
- ARB_MODE=1, both requests re-asserted continuously → ack order W, R, W, R. Repeat with ARB_MODE=0 → W, W, W.
- rst=1 during cyc2 of a write → the next cycle shows cmd=NOP, cmd_addr=0, busy=0, no done. A new request afterwards completes normally.
- WR_LEN=1, TREC=0, wr_req held → cmd sequence ACT, WR, ACT, WR… with done high on each ACT cycle after the first.
